// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter datapath and its input-side sample feeder.
package fir_pkg;

  localparam int FIR_WIDTH  = 16;
  localparam int FIR_LENGTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } feeder_state_e;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO with power-of-two depth, free-running wrap pointers and an
// explicit occupancy counter (0..DEPTH inclusive). Head data is read combinationally.
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             push_ok, pop_ok;

  assign full_o  = (fill_q == CW'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign fill_o  = fill_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + CW'(1);
      2'b01:   fill_d = fill_q - CW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers an upstream sample stream and issues one sample per filter pass as a
// single-cycle fir_valid pulse. Optional watchdog on the filter handshake: FEEDER_TIMEOUT_EN.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int WIDTH   = FIR_WIDTH,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 2 * FIR_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       fir_data,
  output logic                   fir_valid,
  input  logic                   fir_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
  output logic                   timeout
);

  if (TIMEOUT <= FIR_LENGTH + 4) begin : g_timeout_check
    $error("fir_sample_feeder: TIMEOUT must exceed filter LENGTH + 4");
  end

  feeder_state_e    state_q, state_d;
  logic [WIDTH-1:0] fir_data_q, fir_data_d;
  logic             fir_valid_q, busy_q, overflow_q;
  logic [WIDTH-1:0] head;
  logic             full, empty, push, pop, wd_expire;

  assign s_ready   = !full;
  assign push      = s_valid && !full;
  assign fir_data  = fir_data_q;
  assign fir_valid = fir_valid_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

  fir_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (s_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .fill_o      (fill)
  );

  always_comb begin
    state_d    = state_q;
    fir_data_d = fir_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d    = ISSUE;
          fir_data_d = head;
          pop        = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // fir_done outranks the watchdog when both land on the same cycle.
        if (fir_done) begin
          if (!empty) begin
            state_d    = ISSUE;
            fir_data_d = head;
            pop        = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (wd_expire) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fir_data_q  <= '0;
      fir_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fir_data_q  <= fir_data_d;
      fir_valid_q <= (state_d == ISSUE);
      busy_q      <= (state_d != IDLE);
      overflow_q  <= overflow_q | (s_valid & full);
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q;

  // Counter sits at zero outside WAIT, so every WAIT entry starts a fresh count.
  assign wd_cnt_d  = (state_q == WAIT) ? (wd_cnt_q + TW'(1)) : '0;
  assign wd_expire = (state_q == WAIT) && (wd_cnt_q == TW'(TIMEOUT - 1)) && !fir_done;
  assign timeout   = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_q | wd_expire;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: table-driven single-sample vectors,
// hand-written multi-cycle sequences, and a FIFO-ordered scoreboard on fir_data.
module tb_fir_sample_feeder;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int TO = 128;
  localparam int FW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  fir_data;
  logic          fir_valid;
  logic          fir_done;
  logic          busy;
  logic [FW-1:0] fill;
  logic          overflow;
  logic          timeout;

  always #5 clk = ~clk;

  fir_sample_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .fir_data  (fir_data),
    .fir_valid (fir_valid),
    .fir_done  (fir_done),
    .busy      (busy),
    .fill      (fill),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  typedef struct {
    logic [W-1:0] din;
    int           done_dly;
    logic [W-1:0] exp_data;
    int           exp_lat;
  } vec_t;

  vec_t         vecs [4];
  int           n_chk   = 0;
  int           n_pass  = 0;
  int           cyc     = 0;
  int           pulses  = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] sb_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Record accepted samples before the edge, then advance one clock.
  task automatic cycle();
    if (!rst && s_valid && s_ready) exp_q.push_back(s_data);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (!rst && fir_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: pulse with fir_data 0x%0h, expected no pulse", fir_data);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_data", fir_data, sb_e);
      end
    end
  end

  initial begin
    int p0;
    int wait_n;

    vecs[0] = '{din: 16'h1234, done_dly: 64, exp_data: 16'h1234, exp_lat: 2};
    vecs[1] = '{din: 16'hFFFF, done_dly: 1,  exp_data: 16'hFFFF, exp_lat: 2};
    vecs[2] = '{din: 16'h0000, done_dly: 3,  exp_data: 16'h0000, exp_lat: 2};
    vecs[3] = '{din: 16'h8001, done_dly: 10, exp_data: 16'h8001, exp_lat: 2};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; fir_done = 1'b0;
    #1;
    check("rst_fill", fill, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_fir_valid", fir_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout, 0);
    check("rst_fir_data", fir_data, 0);
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Single-sample vectors from an idle, empty feeder.
    for (int i = 0; i < 4; i++) begin
      p0 = pulses;
      s_data = vecs[i].din; s_valid = 1'b1;
      cycle();
      s_valid = 1'b0;
      for (int k = 1; k < vecs[i].exp_lat; k++) begin
        check("tbl_no_early_valid", fir_valid, 0);
        check("tbl_fill_one", fill, 1);
        cycle();
      end
      check("tbl_valid", fir_valid, 1);
      check("tbl_data", fir_data, vecs[i].exp_data);
      cycle();
      for (int j = 1; j < vecs[i].done_dly; j++) begin
        check("tbl_busy_wait", busy, 1);
        check("tbl_hold_data", fir_data, vecs[i].exp_data);
        cycle();
      end
      check("tbl_valid_single", fir_valid, 0);
      fir_done = 1'b1;
      cycle();
      fir_done = 1'b0;
      check("tbl_busy_drop", busy, 0);
      check("tbl_pulse_count", pulses, p0 + 1);
    end

    // Back-to-back: four samples, fir_done 64 cycles after each pulse.
    p0 = pulses;
    s_valid = 1'b1; s_data = 16'h0001; cycle();
    s_data = 16'h0002; cycle();
    check("b2b_first_valid", fir_valid, 1);
    s_data = 16'h0003; cycle();
    s_data = 16'h0004; cycle();
    s_valid = 1'b0;
    wait_n = 61;
    for (int k = 0; k < 4; k++) begin
      repeat (wait_n) cycle();
      wait_n = 63;
      check("b2b_fill", fill, 3 - k);
      check("b2b_busy", busy, 1);
      fir_done = 1'b1;
      cycle();
      fir_done = 1'b0;
      if (k < 3) check("b2b_next_valid", fir_valid, 1);
      else check("b2b_idle", busy, 0);
    end
    check("b2b_fill_zero", fill, 0);
    check("b2b_pulses", pulses, p0 + 4);

    // Spurious fir_done in IDLE and in the ISSUE cycle.
    p0 = pulses;
    fir_done = 1'b1; cycle(); cycle(); fir_done = 1'b0;
    check("spur_idle_busy", busy, 0);
    check("spur_idle_valid", fir_valid, 0);
    s_data = 16'h5A5A; s_valid = 1'b1; cycle(); s_valid = 1'b0;
    cycle();
    check("spur_issue_valid", fir_valid, 1);
    fir_done = 1'b1; cycle(); fir_done = 1'b0;
    check("spur_issue_busy", busy, 1);
    check("spur_issue_valid_low", fir_valid, 0);
    cycle();
    check("spur_still_wait", busy, 1);
    fir_done = 1'b1; cycle(); fir_done = 1'b0;
    check("spur_done_idle", busy, 0);
    check("spur_pulses", pulses, p0 + 1);

    // Full / overflow with the filter stalled; 0xA009 must be dropped.
    for (int i = 0; i < 10; i++) begin
      s_data = 16'hA000 + 16'(i); s_valid = 1'b1;
      if (i == 9) check("ovf_s_ready_low", s_ready, 0);
      cycle();
      if (i == 8) begin
        check("ovf_fill_full", fill, 8);
        check("ovf_not_yet", overflow, 0);
      end
    end
    s_valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_fill_hold", fill, 8);
    for (int i = 0; i < 9; i++) begin
      fir_done = 1'b1; cycle(); fir_done = 1'b0;
      if (i < 8) check("ovf_drain_valid", fir_valid, 1);
      else check("ovf_drain_idle", busy, 0);
      cycle();
    end
    check("ovf_sticky", overflow, 1);
    check("ovf_fill_empty", fill, 0);

    // Asynchronous reset in WAIT with three samples buffered.
    for (int i = 0; i < 4; i++) begin
      s_data = 16'hC001 + 16'(i); s_valid = 1'b1; cycle();
    end
    s_valid = 1'b0;
    cycle();
    check("rstw_fill3", fill, 3);
    check("rstw_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rstw_fill", fill, 0);
    check("rstw_valid", fir_valid, 0);
    check("rstw_busy_clr", busy, 0);
    check("rstw_s_ready", s_ready, 1);
    check("rstw_overflow", overflow, 0);
    exp_q.delete();
    cycle();
    rst = 1'b0;
    cycle(); cycle();
    check("rstw_stays_idle", busy, 0);

`ifdef FEEDER_TIMEOUT_EN
    // fir_done on the expiry cycle wins; then a withheld done trips the watchdog.
    s_valid = 1'b1; s_data = 16'hD001; cycle();
    s_data = 16'hD002; cycle();
    check("to_first_valid", fir_valid, 1);
    s_data = 16'hD003; cycle();
    s_valid = 1'b0;
    repeat (TO - 1) cycle();
    fir_done = 1'b1; cycle(); fir_done = 1'b0;
    check("to_done_wins_valid", fir_valid, 1);
    check("to_done_wins_flag", timeout, 0);
    cycle();
    repeat (TO - 1) cycle();
    check("to_pre_busy", busy, 1);
    check("to_pre_flag", timeout, 0);
    cycle();
    check("to_flag", timeout, 1);
    check("to_idle", busy, 0);
    cycle();
    check("to_next_issue", fir_valid, 1);
    cycle();
    fir_done = 1'b1; cycle(); fir_done = 1'b0;
    check("to_final_idle", busy, 0);
`endif

    cycle();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
